store_rmw_ctrl: RTL and testbench
=================================

// Module: store_rmw_ctrl
// PURPOSE
//  Read-modify-write sequencer between the MEM stage and a word-wide data RAM.
//  Accepts one store (SB/SH/SW) per handshake and checks alignment.
//  Sub-word stores: reads the target word, merges the new byte/half into its lane, writes it back.
//  SW bypasses the read. Stores are serialised; the next request is taken only after the previous write.
// PARAMETERS
//  ADDR_W  32  byte-address width; RAM word address = st_addr[ADDR_W-1:2]
//  RD_LAT  1   RAM read latency in cycles (legal 1..3): ram_rdata valid RD_LAT cycles after the ram_re cycle
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  st_valid   in   1       store request valid
//  st_ready   out  1       controller idle; request accepted when st_valid && st_ready
//  st_type    in   2       0=SB, 1=SH, 2=SW, 3=treated as SW
//  st_addr    in   ADDR_W  byte address
//  st_data    in   32      store data; SB uses [7:0], SH uses [15:0]
//  st_done    out  1       1-cycle pulse in the cycle the RAM write is issued
//  st_err     out  1       1-cycle pulse: misaligned request dropped, no RAM access
//  ram_addr   out  ADDR_W-2  word address, held for the whole operation
//  ram_re     out  1       read strobe
//  ram_rdata  in   32      read data
//  ram_we     out  1       write strobe
//  ram_wdata  out  32      merged write data
// BEHAVIOUR
//  - FSM states: IDLE, READ, WAIT, WRITE, ERR.
//  - Outputs decode from state and registers only. No combinational path from st_* to ram_*.
//  - Reset: state=IDLE, rd counter=0, captured type/addr/data=0.
//    First cycle after reset: st_ready=1, st_done=st_err=ram_re=ram_we=0, ram_addr=0, ram_wdata=0.
//  - IDLE: st_ready=1. On accept, capture type, addr and data, then:
//      misaligned (SH with addr[0]=1, or SW/3 with addr[1:0]!=0) -> ERR
//      SW/3 -> WRITE
//      SB/SH -> READ
//  - READ: ram_re=1 for exactly one cycle; load counter with RD_LAT; go to WAIT.
//  - WAIT: decrement counter each cycle. When the counter reaches 1, register ram_rdata into the merge buffer and go to WRITE.
//  - WRITE: ram_we=1 and st_done=1 for one cycle. Go to IDLE.
//      ram_wdata = captured data for SW.
//      Otherwise ram_wdata = merge(buffer, data, type, addr[1:0]).
//  - ERR: st_err=1 for one cycle; go to IDLE. No ram_re or ram_we.
//  - Merge lanes:
//      SB: addr[1:0]=0..3 selects byte lane [7:0], [15:8], [23:16] or [31:24]; other bytes come from the RAM word.
//      SH: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16].
//  - Latency, accept at cycle T:
//      SW: write at T+1
//      SB/SH: ram_re at T+1, write at T+2+RD_LAT
//      ERR: st_err at T+1
//      st_ready returns high the cycle after WRITE or ERR.
//  - Back-to-back stores to the same word are coherent by serialisation; no forwarding is needed.
//  - st_valid while not ready: ignored. The requester must hold the request until accepted.
//  - Reset mid-operation: takes effect at the next edge. ram_re/ram_we drop to 0 and the pending store is discarded with no st_done.
//  - ram_addr holds st_addr[ADDR_W-1:2] from the accepted request until the next accept.
// STRUCTURE
//  - Package store_pkg: STORE_SB/SH/SW encodings (2'd0/1/2), the state enum, and the RD_LAT legal-range constant.
//  - Sub-module store_merge_unit: purely combinational lane merge with inputs (buffer, data, type, addr_low) and output merged word.
//    Instantiated once; the FSM and counter live in store_rmw_ctrl.
// TESTING
//  1. SW addr 0x10, data 0xDEADBEEF -> ram_we at T+1, ram_addr=0x4, ram_wdata=0xDEADBEEF, st_done at T+1, no ram_re.
//  2. SB addr 0x13, data 0xAA, RAM word 0x11223344, RD_LAT=1 -> ram_re at T+1; write 0xAA223344 at T+3.
//  3. SH addr 0x22, data 0xBEEF, RAM word 0x11223344 -> write 0xBEEF3344. Rerun with RD_LAT=3: write at T+5.
//  4. SH addr 0x21 and SW addr 0x22 -> st_err at T+1, no ram_re/ram_we, st_ready=1 at T+2.
//  5. Two back-to-back SBs to 0x40 (data 0x01) and 0x41 (data 0x02), RAM initially 0 -> final word 0x00000201.
//     st_ready stays low between the two stores.
//  6. rst asserted in the WAIT state of an SB -> no ram_we and no st_done. Next cycle: IDLE, st_ready=1, all strobes 0.

Source files
------------

// File: rtl/store_rmw_ctrl_pkg.sv
// Shared encodings, FSM states and read-latency limits for the store RMW sequencer.
// Imported by the merge unit and the controller.
package store_pkg;

  localparam logic [1:0] STORE_SB = 2'd0;
  localparam logic [1:0] STORE_SH = 2'd1;
  localparam logic [1:0] STORE_SW = 2'd2;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int RD_CNT_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_t;

  // Type 3 shares the SW rules because only bit 1 distinguishes full-word stores.
  function automatic logic misaligned(input logic [1:0] st_type, input logic [1:0] addr_low);
    logic bad;
    bad = 1'b0;
    if (st_type[1])
      bad = (addr_low != 2'd0);
    else if (st_type == STORE_SH)
      bad = addr_low[0];
    return bad;
  endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Store request handshake between the MEM stage (master) and the RMW controller (slave).
interface store_rmw_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [1:0]        st_type;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_done;
  logic              st_err;

  modport master (
    output st_valid, st_type, st_addr, st_data,
    input  st_ready, st_done, st_err
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data,
    output st_ready, st_done, st_err
  );
endinterface

// File: rtl/store_rmw_ctrl_merge.sv
// Lane merge of store data into a RAM word.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module store_merge_unit
  import store_pkg::*;
(
  input  logic [31:0] buffer,
  input  logic [31:0] data,
  input  logic [1:0]  st_type,
  input  logic [1:0]  addr_low,
  output logic [31:0] merged
);

  always_comb begin
    merged = buffer;
    case (st_type)
      STORE_SB: begin
        case (addr_low)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      STORE_SH: begin
        if (addr_low[1])
          merged[31:16] = data[15:0];
        else
          merged[15:0]  = data[15:0];
      end
      default: merged = data;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Serialising read-modify-write store sequencer in front of a word-wide data RAM.
// Latency: SW write at T+1, SB/SH write at T+2+RD_LAT, misaligned error at T+1.
// Backpressure: st_ready only in IDLE; one store in flight at a time.
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  store_rmw_ctrl_if.slave   st,
  output logic [ADDR_W-3:0] ram_addr,
  output logic              ram_re,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we,
  output logic [31:0]       ram_wdata
);

  // Out-of-range latencies clamp into the supported window.
  localparam int RD_LAT_C = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                            (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_t              state, state_nxt;
  logic [RD_CNT_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [1:0]          cap_type;
  logic [ADDR_W-1:0]   cap_addr;
  logic [31:0]         cap_data;
  logic [31:0]         merge_buf;
  logic                accept;
  logic                buf_load;
  logic [31:0]         merged;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rd_cnt    <= '0;
      cap_type  <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      merge_buf <= '0;
    end else begin
      state  <= state_nxt;
      rd_cnt <= rd_cnt_nxt;
      if (accept) begin
        cap_type <= st.st_type;
        cap_addr <= st.st_addr;
        cap_data <= st.st_data;
      end
      if (buf_load)
        merge_buf <= ram_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    accept     = 1'b0;
    buf_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (st.st_valid) begin
          accept = 1'b1;
          if (misaligned(st.st_type, st.st_addr[1:0]))
            state_nxt = ST_ERR;
          else if (st.st_type[1])
            state_nxt = ST_WRITE;
          else
            state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        rd_cnt_nxt = RD_CNT_W'(RD_LAT_C);
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        rd_cnt_nxt = rd_cnt - 2'd1;
        // Count of 1 marks the cycle the RAM word is on ram_rdata.
        if (rd_cnt == 2'd1) begin
          buf_load  = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  store_merge_unit u_merge (
    .buffer   (merge_buf),
    .data     (cap_data),
    .st_type  (cap_type),
    .addr_low (cap_addr[1:0]),
    .merged   (merged)
  );

  assign st.st_ready = (state == ST_IDLE);
  assign st.st_done  = (state == ST_WRITE);
  assign st.st_err   = (state == ST_ERR);
  assign ram_re      = (state == ST_READ);
  assign ram_we      = (state == ST_WRITE);
  assign ram_addr    = cap_addr[ADDR_W-1:2];
  assign ram_wdata   = merged;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl: RD_LAT=1 and RD_LAT=3 instances sharing one request driver.
module tb_store_rmw_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        drv_valid = 1'b0;
  logic [1:0]  drv_type = 2'd0;
  logic [31:0] drv_addr = 32'd0;
  logic [31:0] drv_data = 32'd0;

  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'd0;

  store_rmw_ctrl_if #(.ADDR_W(32)) sif1 ();
  store_rmw_ctrl_if #(.ADDR_W(32)) sif3 ();

  assign sif1.st_valid = drv_valid & ~sel;
  assign sif1.st_type  = drv_type;
  assign sif1.st_addr  = drv_addr;
  assign sif1.st_data  = drv_data;
  assign sif3.st_valid = drv_valid & sel;
  assign sif3.st_type  = drv_type;
  assign sif3.st_addr  = drv_addr;
  assign sif3.st_data  = drv_data;

  logic [29:0] ram_addr1, ram_addr3;
  logic        ram_re1, ram_re3, ram_we1, ram_we3;
  logic [31:0] ram_rdata1, ram_rdata3, ram_wdata1, ram_wdata3;

  store_rmw_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .st(sif1.slave),
    .ram_addr(ram_addr1), .ram_re(ram_re1), .ram_rdata(ram_rdata1),
    .ram_we(ram_we1), .ram_wdata(ram_wdata1)
  );

  store_rmw_ctrl #(.ADDR_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .st(sif3.slave),
    .ram_addr(ram_addr3), .ram_re(ram_re3), .ram_rdata(ram_rdata3),
    .ram_we(ram_we3), .ram_wdata(ram_wdata3)
  );

  // RAM models: read data is present for exactly one cycle, RD_LAT cycles after ram_re.
  logic [31:0] mem1 [0:63];
  logic [31:0] mem3 [0:63];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (pre_en) begin
      mem1[pre_idx] <= pre_val;
      mem3[pre_idx] <= pre_val;
    end
    if (ram_we1) mem1[ram_addr1[5:0]] <= ram_wdata1;
    if (ram_we3) mem3[ram_addr3[5:0]] <= ram_wdata3;
    p1    <= ram_re1 ? mem1[ram_addr1[5:0]] : 32'hBAD0_BAD0;
    p3[0] <= ram_re3 ? mem3[ram_addr3[5:0]] : 32'hBAD0_BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ram_rdata1 = p1;
  assign ram_rdata3 = p3[2];

  logic        obs_ready, obs_done, obs_err, obs_re, obs_we;
  logic [29:0] obs_addr;
  logic [31:0] obs_wdata;
  assign obs_ready = sel ? sif3.st_ready : sif1.st_ready;
  assign obs_done  = sel ? sif3.st_done  : sif1.st_done;
  assign obs_err   = sel ? sif3.st_err   : sif1.st_err;
  assign obs_re    = sel ? ram_re3       : ram_re1;
  assign obs_we    = sel ? ram_we3       : ram_we1;
  assign obs_addr  = sel ? ram_addr3     : ram_addr1;
  assign obs_wdata = sel ? ram_wdata3    : ram_wdata1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        lat3;
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] init;
    logic [31:0] wdata;
    int          re_cyc;
    int          we_cyc;
    int          err_cyc;
    int          rdy_cyc;
  } vec_t;

  function automatic vec_t mk(input logic lat3, input logic [1:0] typ, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] init, input logic [31:0] wdata,
                              input int re_cyc, input int we_cyc, input int err_cyc, input int rdy_cyc);
    vec_t v;
    v.lat3 = lat3; v.typ = typ; v.addr = addr; v.data = data; v.init = init; v.wdata = wdata;
    v.re_cyc = re_cyc; v.we_cyc = we_cyc; v.err_cyc = err_cyc; v.rdy_cyc = rdy_cyc;
    return v;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(obs_ready), 32'd1);
    chk({tag, "_done"},  32'(obs_done),  32'd0);
    chk({tag, "_err"},   32'(obs_err),   32'd0);
    chk({tag, "_re"},    32'(obs_re),    32'd0);
    chk({tag, "_we"},    32'(obs_we),    32'd0);
    chk({tag, "_addr"},  32'(obs_addr),  32'd0);
    chk({tag, "_wdata"}, obs_wdata,      32'd0);
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] val);
    @(negedge clk);
    pre_idx = byte_addr[7:2];
    pre_val = val;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int re_c, we_c, err_c, done_c, rdy_c, n_re, n_we;
    logic [31:0] wd;
    logic [29:0] a1;
    string tag;
    tag = $sformatf("v%0d", idx);
    sel = v.lat3;
    preload(v.addr, v.init);
    chk({tag, "_ready_before"}, 32'(obs_ready), 32'd1);
    drv_valid = 1'b1; drv_type = v.typ; drv_addr = v.addr; drv_data = v.data;
    @(negedge clk);
    drv_valid = 1'b0;
    re_c = 0; we_c = 0; err_c = 0; done_c = 0; rdy_c = 0; n_re = 0; n_we = 0;
    wd = 32'd0; a1 = obs_addr;
    for (int k = 1; k <= 8; k++) begin
      if (obs_re) begin n_re++; if (re_c == 0) re_c = k; end
      if (obs_we) begin n_we++; if (we_c == 0) begin we_c = k; wd = obs_wdata; end end
      if (obs_err && err_c == 0) err_c = k;
      if (obs_done && done_c == 0) done_c = k;
      if (obs_ready && rdy_c == 0) rdy_c = k;
      if (k < 8) @(negedge clk);
    end
    chk({tag, "_ram_addr"}, 32'(a1), {2'b00, v.addr[31:2]});
    chk({tag, "_re_cyc"},   32'(re_c),  32'(v.re_cyc));
    chk({tag, "_re_cnt"},   32'(n_re),  (v.re_cyc != 0) ? 32'd1 : 32'd0);
    chk({tag, "_we_cyc"},   32'(we_c),  32'(v.we_cyc));
    chk({tag, "_we_cnt"},   32'(n_we),  (v.we_cyc != 0) ? 32'd1 : 32'd0);
    chk({tag, "_done_cyc"}, 32'(done_c), 32'(v.we_cyc));
    chk({tag, "_err_cyc"},  32'(err_c), 32'(v.err_cyc));
    chk({tag, "_rdy_cyc"},  32'(rdy_c), 32'(v.rdy_cyc));
    if (v.we_cyc != 0)
      chk({tag, "_wdata"}, wd, v.wdata);
  endtask

  vec_t vecs [0:13];

  initial begin
    int k;
    logic [31:0] first_wd;
    logic        got;

    vecs[0]  = mk(1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 1, 0, 2);
    vecs[1]  = mk(1'b0, 2'd0, 32'h13, 32'h000000AA, 32'h11223344, 32'hAA223344, 1, 3, 0, 4);
    vecs[2]  = mk(1'b0, 2'd1, 32'h22, 32'h0000BEEF, 32'h11223344, 32'hBEEF3344, 1, 3, 0, 4);
    vecs[3]  = mk(1'b1, 2'd1, 32'h22, 32'h0000BEEF, 32'h11223344, 32'hBEEF3344, 1, 5, 0, 6);
    vecs[4]  = mk(1'b0, 2'd1, 32'h21, 32'h0000BEEF, 32'h11223344, 32'h0,        0, 0, 1, 2);
    vecs[5]  = mk(1'b0, 2'd2, 32'h22, 32'hCAFEF00D, 32'h11223344, 32'h0,        0, 0, 1, 2);
    vecs[6]  = mk(1'b0, 2'd0, 32'h20, 32'h00000055, 32'h11223344, 32'h11223355, 1, 3, 0, 4);
    vecs[7]  = mk(1'b0, 2'd0, 32'h15, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFF00FF, 1, 3, 0, 4);
    vecs[8]  = mk(1'b0, 2'd0, 32'h22, 32'h00000077, 32'h00000000, 32'h00770000, 1, 3, 0, 4);
    vecs[9]  = mk(1'b0, 2'd1, 32'h30, 32'hABCD1234, 32'hAABBCCDD, 32'hAABB1234, 1, 3, 0, 4);
    vecs[10] = mk(1'b0, 2'd3, 32'h34, 32'h0BADF00D, 32'h0,        32'h0BADF00D, 0, 1, 0, 2);
    vecs[11] = mk(1'b0, 2'd3, 32'h35, 32'h0BADF00D, 32'h0,        32'h0,        0, 0, 1, 2);
    vecs[12] = mk(1'b1, 2'd0, 32'h17, 32'h0000005A, 32'h01020304, 32'h5A020304, 1, 5, 0, 6);
    vecs[13] = mk(1'b1, 2'd2, 32'h18, 32'h12345678, 32'h0,        32'h12345678, 0, 1, 0, 2);

    // Reset state, both instances.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sel = 1'b0; #1; chk_reset_state("rst1");
    sel = 1'b1; #1; chk_reset_state("rst3");
    sel = 1'b0;

    for (int i = 0; i < 14; i++)
      run_vec(i, vecs[i]);

    // Back-to-back SBs into one word, second request held while busy.
    sel = 1'b0;
    preload(32'h40, 32'h0);
    drv_valid = 1'b1; drv_type = 2'd0; drv_addr = 32'h40; drv_data = 32'h01;
    @(negedge clk);
    drv_addr = 32'h41; drv_data = 32'h02;
    got = 1'b0; first_wd = 32'd0;
    for (k = 1; k <= 20; k++) begin
      if (obs_we && !got) begin first_wd = obs_wdata; got = 1'b1; end
      if (obs_ready) break;
      @(negedge clk);
    end
    chk("b2b_ready_cyc", 32'(k), 32'd4);
    chk("b2b_first_wdata", first_wd, 32'h00000001);
    @(negedge clk);
    drv_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      if (obs_we) break;
      @(negedge clk);
    end
    chk("b2b_second_we_cyc", 32'(k), 32'd3);
    chk("b2b_second_wdata", obs_wdata, 32'h00000201);
    @(negedge clk);
    chk("b2b_final_word", mem1[16], 32'h00000201);

    // Reset during WAIT of an SB discards the store.
    preload(32'h14, 32'h0);
    drv_valid = 1'b1; drv_type = 2'd0; drv_addr = 32'h14; drv_data = 32'h99;
    @(negedge clk);
    drv_valid = 1'b0;
    chk("rstwait_re", 32'(obs_re), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    chk("rstwait_no_we_in_wait", 32'(obs_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("rstwait");
    got = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (obs_we || obs_done) got = 1'b1;
      @(negedge clk);
    end
    chk("rstwait_no_write_after", 32'(got), 32'd0);
    chk("rstwait_word_untouched", mem1[5], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
